instr_fetch: RTL and testbench

Instruction fetch unit driving the `control_unit` decode stage. It holds the PC and issues word requests to instruction memory over a valid/ready handshake. Returned words are buffered in a small in-order FIFO and presented to decode as the raw instruction, its PC and the pre-split `opcode`/`funct3`/`funct7` fields. Branch and jump redirects from execute flush the buffer and discard in-flight responses.

---
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC/request generator with an in-order response FIFO feeding decode.
// Define FETCH_MISALIGN_TRAP_EN to trap and halt on misaligned redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        misalign
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] pc;
  logic [CW-1:0] inflight, drop_cnt, cnt;
  logic [AW-1:0] qw, qr, wp, rp;
  logic [31:0] pcq [BUF_DEPTH];
  logic [31:0] dq [BUF_DEPTH];
  logic [31:0] aq [BUF_DEPTH];
  logic req_fire, push, pop, drop, trap, flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_flag;
  assign trap = redirect_valid && redirect_pc[1:0] != 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) trap_flag <= 1'b0;
    else if (trap) trap_flag <= 1'b1;
  assign misalign = trap_flag;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign trap = 1'b0;
  assign misalign = 1'b0;
`endif
  always_comb begin
    state_nxt = trap ? HALT : (state == BOOT ? RUN : state);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nxt;
  assign flush = redirect_valid || state == HALT;
  assign imem_req_valid = state == RUN && !redirect_valid && ({1'b0, inflight} + {1'b0, cnt}) < DEPTH;
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign drop = imem_rsp_valid && drop_cnt != '0;
  assign push = imem_rsp_valid && drop_cnt == '0 && !flush;
  assign pop = out_valid && out_ready;
  assign out_valid = cnt != '0;
  assign out_instr = dq[rp];
  assign out_pc = aq[rp];
  assign opcode = out_instr[6:0];
  assign funct3 = out_instr[14:12];
  assign funct7 = out_instr[31:25];
  // The request-address queue advances on every response, dropped or not, so it stays aligned with memory order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      cnt <= '0;
      qw <= '0;
      qr <= '0;
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pcq[i] <= '0;
        dq[i] <= '0;
        aq[i] <= '0;
      end
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_cnt <= redirect_valid ? inflight - CW'(imem_rsp_valid) : drop_cnt - CW'(drop);
      if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire) pc <= pc + 32'd4;
      if (req_fire) begin
        pcq[qw] <= pc;
        qw <= qw + AW'(1);
      end
      if (imem_rsp_valid) qr <= qr + AW'(1);
      if (push) begin
        dq[wp] <= imem_rsp_data;
        aq[wp] <= pcq[qr];
        wp <= wp + AW'(1);
      end
      if (flush) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (pop) rp <= rp + AW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch with a stallable in-order memory model.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic misalign;
  int checks = 0;
  int failures = 0;
  int mark, omark;
  logic mem_stall = 1'b0;
  logic [63:0] expq[$];
  logic [31:0] memq[$];
  logic [31:0] reqs[$];
  logic [31:0] outs[$];
  always #5 clk = ~clk;
  instr_fetch #(.RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .misalign(misalign)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h108 ? 32'h0020_8033 : ((a ^ 32'h5A5A_0000) | 32'h3);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // Called at a negedge: drive this cycle's memory response, score outputs, log requests.
  task automatic mon();
    logic [31:0] e_pc, e_in;
    imem_rsp_valid = !mem_stall && memq.size() > 0;
    imem_rsp_data = 32'h0;
    if (imem_rsp_valid) imem_rsp_data = memq.pop_front();
    if (out_valid && out_ready) begin
      outs.push_back(out_pc);
      if (expq.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'h0);
      else begin
        {e_pc, e_in} = expq.pop_front();
        chk("out_pc", out_pc, e_pc);
        chk("out_instr", out_instr, e_in);
        chk("opcode", {25'b0, opcode}, {25'b0, e_in[6:0]});
        chk("funct3", {29'b0, funct3}, {29'b0, e_in[14:12]});
        chk("funct7", {25'b0, funct7}, {25'b0, e_in[31:25]});
        if (e_pc == 32'h108) begin
          chk("add_opcode", {25'b0, opcode}, 32'h33);
          chk("add_funct3", {29'b0, funct3}, 32'h0);
          chk("add_funct7", {25'b0, funct7}, 32'h0);
        end
      end
    end
    if (redirect_valid) expq.delete();
    if (imem_req_valid && imem_req_ready) begin
      reqs.push_back(imem_req_addr);
      memq.push_back(mem_word(imem_req_addr));
      expq.push_back({imem_req_addr, mem_word(imem_req_addr)});
    end
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  initial begin
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fields", {12'b0, opcode, funct3, funct7}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("boot_no_req", {31'b0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1;
    tick();
    chk("first_req_cycle", reqs.size(), 32'd1);
    tick();
    @(negedge clk);
    chk("lat_out_valid", {31'b0, out_valid}, 32'h1);
    chk("lat_out_pc", out_pc, 32'h100);
    mon();
    @(posedge clk);
    #1;
    repeat (12) tick();
    chk("req0", reqs[0], 32'h100);
    chk("req1", reqs[1], 32'h104);
    chk("req2", reqs[2], 32'h108);
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    mark = reqs.size();
    repeat (6) tick();
    chk("stall_req_count", reqs.size() - mark, 32'd2);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("stall_req_a", reqs[mark], 32'h300);
    chk("stall_req_b", reqs[mark+1], 32'h304);
    omark = outs.size();
    out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_a", outs[omark], 32'h300);
    chk("drain_b", outs[omark+1], 32'h304);
    mem_stall = 1'b1;
    repeat (4) tick();
    chk("credit_stop", {31'b0, imem_req_valid}, 32'h0);
    chk("pre_redir_empty", {31'b0, out_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("redir_empty", {31'b0, out_valid}, 32'h0);
    mark = reqs.size();
    omark = outs.size();
    mem_stall = 1'b0;
    repeat (10) tick();
    chk("redir_req", reqs[mark], 32'h200);
    chk("redir_out", outs[omark], 32'h200);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    chk("hold_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("hold_addr", imem_req_addr, 32'hFFFF_FFF8);
    tick();
    chk("hold_valid2", {31'b0, imem_req_valid}, 32'h1);
    chk("hold_addr2", imem_req_addr, 32'hFFFF_FFF8);
    imem_req_ready = 1'b1;
    mark = reqs.size();
    repeat (10) tick();
    chk("wrap_a", reqs[mark], 32'hFFFF_FFF8);
    chk("wrap_b", reqs[mark+1], 32'hFFFF_FFFC);
    chk("wrap_c", reqs[mark+2], 32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    mark = reqs.size();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_set", {31'b0, misalign}, 32'h1);
    repeat (6) tick();
    chk("halt_no_req", reqs.size() - mark, 32'd0);
    chk("halt_out_valid", {31'b0, out_valid}, 32'h0);
    chk("halt_misalign", {31'b0, misalign}, 32'h1);
`else
    repeat (6) tick();
    chk("misalign_off", {31'b0, misalign}, 32'h0);
    chk("aligned_req", reqs[mark], 32'h200);
`endif
    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
